cipher_round_sequencer: RTL and testbench
=========================================

// Module: cipher_round_sequencer
//
// PURPOSE
// Sequences the iterative cipher datapath for one 64-bit block at a time.
// Pulls a block from the receive FIFO once the key schedule is ready.
// Steps the round datapath through NUM_ROUNDS rounds, with subkey order set by encrypt/decrypt mode.
// Pushes the result into the transmit FIFO, honouring full backpressure.
// Sits between the MCU (mode, key-ready flag) and the round core / Rx / Tx FIFOs.
//
// PARAMETERS
// NUM_ROUNDS   16  number of cipher rounds per block (>=2)
// RND_W        4   width of round index; 2**RND_W >= NUM_ROUNDS
// CNT_W        16  width of completed-block counter
//
// PORTS
// clk          in   1      system clock, rising edge
// n_reset      in   1      asynchronous, active-low reset
// key_ready    in   1      key schedule generated and valid (level)
// is_encrypt   in   1      1 = encrypt, 0 = decrypt; sampled at FETCH only
// abort        in   1      synchronous soft clear, back to IDLE
// rx_empty     in   1      receive FIFO empty
// rx_deq       out  1      one-cycle dequeue strobe to receive FIFO
// load_block   out  1      datapath loads FIFO output into block register
// round_en     out  1      datapath performs one round this cycle
// round_idx    out  RND_W  current round number, 0..NUM_ROUNDS-1
// subkey_sel   out  RND_W  subkey index: enc = round_idx, dec = NUM_ROUNDS-1-round_idx
// tx_full      in   1      transmit FIFO full
// tx_enq       out  1      one-cycle enqueue strobe to transmit FIFO
// busy         out  1      state != IDLE
// block_count  out  CNT_W  blocks written to Tx since reset; wraps modulo 2**CNT_W
//
// BEHAVIOUR
// Reset: state = IDLE; round counter = 0; mode_q = 1; block_count = 0.
//   All strobes are 0 in reset.
// Outputs are decoded from registered state only; no input->output combinational path.
// States and transitions:
//   IDLE:  key_ready && !rx_empty -> FETCH; otherwise stay.
//   FETCH: rx_deq = 1; mode_q <= is_encrypt -> LOAD.
//   LOAD:  load_block = 1; round counter <= 0 -> ROUND.
//   ROUND: round_en = 1; counter increments each cycle.
//          Counter == NUM_ROUNDS-1 -> WRITE.
//   WRITE: if !tx_full: tx_enq = 1, block_count++.
//          Then FETCH if key_ready && !rx_empty, else IDLE.
//          If tx_full: stay in WRITE, tx_enq = 0, block held.
// Latency, NUM_ROUNDS=16: IDLE decision in cycle c -> rx_deq c+1, load_block c+2,
//   round_en c+3..c+18, tx_enq c+19 if Tx not full.
// Back-to-back throughput: one block per NUM_ROUNDS+3 cycles.
// round_idx and subkey_sel are 0 outside ROUND.
// mode_q is held for the whole block; is_encrypt changes mid-block are ignored.
// key_ready dropping mid-block: current block completes; no new FETCH until it returns.
// rx_empty is evaluated only in IDLE and WRITE; FETCH is never entered with rx_empty = 1.
// abort has priority over all transitions: next state IDLE, strobes 0 that cycle.
//   Any in-flight block is discarded and block_count is unchanged.
//   mode_q is retained.
// Asynchronous reset mid-block: immediate return to reset values; block lost.
//
// TESTING
// 1. key_ready=1, one block in Rx, is_encrypt=1 -> rx_deq at c+1, load at c+2;
//    round_idx=subkey_sel=0..15 over c+3..c+18; tx_enq at c+19; block_count=1.
// 2. Same with is_encrypt=0 -> subkey_sel=15..0 while round_idx=0..15.
//    Toggle is_encrypt mid-rounds -> sequence unchanged.
// 3. key_ready=0 with Rx non-empty for 50 cycles -> rx_deq never asserts.
//    Raise key_ready -> FETCH next cycle.
// 4. tx_full=1 when WRITE is reached, held 10 cycles -> tx_enq=0 throughout.
//    Release -> tx_enq single pulse next cycle, count +1.
// 5. 3 blocks queued -> tx_enq pulses exactly 19 cycles apart; block_count=3.
// 6. abort at round 7 -> IDLE next cycle, no tx_enq, block_count unchanged.
//    Preload block_count=0xFFFF, complete one block -> 0x0000.

Source files
------------

// File: rtl/cipher_round_sequencer.sv
// cipher_round_sequencer: pulls a block from Rx, steps NUM_ROUNDS cipher rounds with
// mode-dependent subkey order, then pushes the result to Tx under full backpressure.
module cipher_round_sequencer #(
    parameter int NUM_ROUNDS = 16,
    parameter int RND_W      = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             key_ready_i,
    input  logic             is_encrypt_i,
    input  logic             abort_i,
    input  logic             rx_empty_i,
    output logic             rx_deq_o,
    output logic             load_block_o,
    output logic             round_en_o,
    output logic [RND_W-1:0] round_idx_o,
    output logic [RND_W-1:0] subkey_sel_o,
    input  logic             tx_full_i,
    output logic             tx_enq_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] block_count_o
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, ROUND, WRITE} state_t;
    localparam logic [RND_W-1:0] LAST = RND_W'(NUM_ROUNDS - 1);
    state_t           state_q;
    logic             mode_q, rx_deq_q, load_q, round_en_q, tx_enq_q;
    logic [RND_W-1:0] idx_q, sk_q;
    logic [CNT_W-1:0] count_q;
    // Strobes are registered alongside the state, so each is set on the edge entering its cycle.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= IDLE;
            mode_q     <= 1'b1;
            rx_deq_q   <= 1'b0;
            load_q     <= 1'b0;
            round_en_q <= 1'b0;
            tx_enq_q   <= 1'b0;
            idx_q      <= '0;
            sk_q       <= '0;
            count_q    <= '0;
        end else begin
            rx_deq_q   <= 1'b0;
            load_q     <= 1'b0;
            round_en_q <= 1'b0;
            tx_enq_q   <= 1'b0;
            idx_q      <= '0;
            sk_q       <= '0;
            if (abort_i) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: if (key_ready_i && !rx_empty_i) begin
                        state_q  <= FETCH;
                        rx_deq_q <= 1'b1;
                    end
                    FETCH: begin
                        mode_q  <= is_encrypt_i;
                        state_q <= LOAD;
                        load_q  <= 1'b1;
                    end
                    LOAD: begin
                        state_q    <= ROUND;
                        round_en_q <= 1'b1;
                        sk_q       <= mode_q ? '0 : LAST;
                    end
                    ROUND: if (idx_q == LAST) begin
                        state_q <= WRITE;
                        if (!tx_full_i) begin
                            tx_enq_q <= 1'b1;
                            count_q  <= count_q + 1'b1;
                        end
                    end else begin
                        round_en_q <= 1'b1;
                        idx_q      <= idx_q + 1'b1;
                        sk_q       <= mode_q ? idx_q + 1'b1 : LAST - idx_q - 1'b1;
                    end
                    WRITE: if (tx_enq_q) begin
                        state_q  <= (key_ready_i && !rx_empty_i) ? FETCH : IDLE;
                        rx_deq_q <= key_ready_i && !rx_empty_i;
                    end else if (!tx_full_i) begin
                        tx_enq_q <= 1'b1;
                        count_q  <= count_q + 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
    assign rx_deq_o      = rx_deq_q;
    assign load_block_o  = load_q;
    assign round_en_o    = round_en_q;
    assign round_idx_o   = idx_q;
    assign subkey_sel_o  = sk_q;
    assign tx_enq_o      = tx_enq_q;
    assign busy_o        = state_q != IDLE;
    assign block_count_o = count_q;
endmodule

// File: tb/tb_cipher_round_sequencer.sv
// tb_cipher_round_sequencer: directed and random stimulus checked cycle by cycle against
// a block-timeline model (position within the block, Rx occupancy, pending Tx write).
module tb_cipher_round_sequencer;
    localparam int N = 16;
    localparam int CW = 4;
    logic clk = 1'b0, n_reset = 1'b0;
    logic key_ready = 1'b0, is_encrypt = 1'b0, abort = 1'b0, rx_empty = 1'b1, tx_full = 1'b0;
    logic rx_deq, load_block, round_en, tx_enq, busy;
    logic [3:0] round_idx, subkey_sel;
    logic [CW-1:0] block_count;
    int n_vec = 0, n_err = 0;
    int m_t = 0, m_cnt = 0, rx_cnt = 0;
    bit m_enq = 0, m_mode = 1;

    cipher_round_sequencer #(.NUM_ROUNDS(N), .RND_W(4), .CNT_W(CW)) dut (
        .clk(clk), .n_reset(n_reset), .key_ready_i(key_ready), .is_encrypt_i(is_encrypt),
        .abort_i(abort), .rx_empty_i(rx_empty), .rx_deq_o(rx_deq), .load_block_o(load_block),
        .round_en_o(round_en), .round_idx_o(round_idx), .subkey_sel_o(subkey_sel),
        .tx_full_i(tx_full), .tx_enq_o(tx_enq), .busy_o(busy), .block_count_o(block_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    // m_t: 0 idle, 1 fetch, 2 load, 3..N+2 rounds, N+3 write-back
    task automatic check_all();
        bit in_round = m_t >= 3 && m_t <= N + 2;
        int r = m_t - 3;
        check("rx_deq", rx_deq, m_t == 1);
        check("load_block", load_block, m_t == 2);
        check("round_en", round_en, in_round);
        check("round_idx", round_idx, in_round ? r : 0);
        check("subkey_sel", subkey_sel, in_round ? (m_mode ? r : N - 1 - r) : 0);
        check("tx_enq", tx_enq, m_enq);
        check("busy", busy, m_t != 0);
        check("block_count", block_count, m_cnt % (1 << CW));
    endtask

    task automatic model_step(input bit kr, enc, ab, full, empty);
        bit was_enq = m_enq;
        bit go = kr && !empty;
        m_enq = 0;
        if (ab) m_t = 0;
        else if (m_t == 0) m_t = go ? 1 : 0;
        else if (m_t == 1) begin m_mode = enc; m_t = 2; end
        else if (m_t < N + 2) m_t++;
        else if (m_t == N + 2 || !was_enq) begin
            m_t = N + 3;
            if (!full) begin m_enq = 1; m_cnt++; end
        end else m_t = go ? 1 : 0;
    endtask

    // Called just after a falling edge; applies inputs for one cycle and checks after the rising edge.
    task automatic step(input bit kr, enc, ab, full, input int push);
        bit empty = rx_cnt == 0;
        key_ready = kr; is_encrypt = enc; abort = ab; tx_full = full; rx_empty = empty;
        @(posedge clk);
        if (m_t == 1) rx_cnt--;
        model_step(kr, enc, ab, full, empty);
        rx_cnt += push;
        #1 check_all();
        @(negedge clk);
    endtask

    task automatic async_reset();
        n_reset = 1'b0;
        #1;
        m_t = 0; m_enq = 0; m_cnt = 0; m_mode = 1;
        check_all();
        #2 n_reset = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        async_reset();
        // single encrypt block
        rx_cnt = 1;
        for (int i = 0; i < 24; i++) step(1, 1, 0, 0, 0);
        // decrypt block with is_encrypt toggling after fetch
        rx_cnt = 1;
        for (int i = 0; i < 24; i++) step(1, (i < 2) ? 1'b0 : 1'($urandom), 0, 0, 0);
        // key not ready: nothing fetched, then released
        rx_cnt = 3;
        for (int i = 0; i < 50; i++) step(0, 1, 0, 0, 0);
        for (int i = 0; i < 62; i++) step(1, 1, 0, 0, 0);
        // Tx full over the write-back
        rx_cnt = 1;
        for (int i = 0; i < 45; i++) step(1, 0, 0, i >= 15 && i < 32, 0);
        // abort at round 7
        rx_cnt = 1;
        for (int i = 0; i < 30; i++) step(1, 1, m_t == 10, 0, 0);
        // async reset mid-block
        rx_cnt = 2;
        for (int i = 0; i < 9; i++) step(1, 1, 0, 0, 0);
        async_reset();
        for (int i = 0; i < 45; i++) step(1, 1, 0, 0, 0);
        // random traffic; block_count wraps several times
        for (int i = 0; i < 3000; i++)
            step($urandom_range(7) != 0, 1'($urandom), $urandom_range(199) == 0,
                 $urandom_range(3) == 0, int'($urandom_range(5) == 0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
